// File: rtl/memwb_writeback.sv
// MEM/WB pipeline register and writeback select for SimpleRISC.
// Holds the MEM/WB register, waits for load data from data memory and picks the
// value written to the register file. Also drives the WB->EXT forwarding register
// (rd/data plus its stall) and back-pressures MEM while a load is outstanding.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   valid_MEM       MEM stage presents an instruction
//   rd_MEM          destination register
//   ALUResult_MEM   ALU result
//   PC_MEM          instruction PC (call return address = PC + 4)
//   isWb_MEM        instruction writes a register
//   isLd_MEM        instruction is a load
//   isCall_MEM      instruction is a call
//   mem_rvalid      load data valid (single-cycle pulse)
//   mem_rdata       load data
//   stall_MEM       hold the MEM stage while a load is outstanding
//   rd_WB           writeback register index
//   WriteData_WB    writeback data
//   RegWrite_WB     register-file write enable
//   stall_WBEXT     hold the WB->EXT forwarding register (no write this cycle)
//   err_timeout     sticky load-timeout flag, cleared only by reset
module memwb_writeback #(
    parameter int unsigned RA_REG  = 15,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_MEM,
    input  logic [4:0]  rd_MEM,
    input  logic [31:0] ALUResult_MEM,
    input  logic [31:0] PC_MEM,
    input  logic        isWb_MEM,
    input  logic        isLd_MEM,
    input  logic        isCall_MEM,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        stall_MEM,
    output logic [4:0]  rd_WB,
    output logic [31:0] WriteData_WB,
    output logic        RegWrite_WB,
    output logic        stall_WBEXT,
    output logic        err_timeout
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   data_q, data_d;
    logic          we_q, we_d;
    logic          iswb_q, iswb_d;
    logic          err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        data_d  = data_q;
        we_d    = we_q;
        iswb_d  = iswb_q;
        err_d   = err_q;
        case (state_q)
            StIdle, StDone: begin
                // DONE accepts exactly like IDLE; the written-back load already
                // sits in the output registers for this cycle.
                if (!valid_MEM) begin
                    we_d    = 1'b0;
                    state_d = StIdle;
                end else if (isLd_MEM) begin
                    rd_d    = rd_MEM;
                    we_d    = 1'b0;
                    iswb_d  = isWb_MEM;
                    cnt_d   = '0;
                    state_d = StWait;
                end else begin
                    we_d    = isWb_MEM;
                    state_d = StIdle;
                    if (isCall_MEM) begin
                        rd_d   = 5'(RA_REG);
                        data_d = PC_MEM + 32'd4;
                    end else begin
                        rd_d   = rd_MEM;
                        data_d = ALUResult_MEM;
                    end
                end
            end
            StWait: begin
                we_d = 1'b0;
                // Data arriving in the last allowed cycle still wins over timeout.
                if (mem_rvalid) begin
                    data_d  = mem_rdata;
                    we_d    = iswb_q;
                    state_d = StDone;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                we_d    = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            iswb_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            we_q    <= we_d;
            iswb_q  <= iswb_d;
            err_q   <= err_d;
        end
    end

    assign stall_MEM    = (state_q == StWait);
    assign rd_WB        = rd_q;
    assign WriteData_WB = data_q;
    assign RegWrite_WB  = we_q;
    assign stall_WBEXT  = ~we_q;
    assign err_timeout  = err_q;

endmodule

// File: tb/tb_memwb_writeback.sv
// Scoreboard bench for memwb_writeback: the driver advances a behavioural model at
// every rising edge and queues the expected post-edge outputs; a monitor pops and
// compares them on the falling edge. Includes a bench-side WB->EXT register.
module tb_memwb_writeback;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        rst_n;
    logic        valid_MEM;
    logic [4:0]  rd_MEM;
    logic [31:0] ALUResult_MEM;
    logic [31:0] PC_MEM;
    logic        isWb_MEM;
    logic        isLd_MEM;
    logic        isCall_MEM;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall_MEM;
    logic [4:0]  rd_WB;
    logic [31:0] WriteData_WB;
    logic        RegWrite_WB;
    logic        stall_WBEXT;
    logic        err_timeout;

    memwb_writeback #(
        .RA_REG (15),
        .TIMEOUT(TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_MEM    (valid_MEM),
        .rd_MEM       (rd_MEM),
        .ALUResult_MEM(ALUResult_MEM),
        .PC_MEM       (PC_MEM),
        .isWb_MEM     (isWb_MEM),
        .isLd_MEM     (isLd_MEM),
        .isCall_MEM   (isCall_MEM),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .stall_MEM    (stall_MEM),
        .rd_WB        (rd_WB),
        .WriteData_WB (WriteData_WB),
        .RegWrite_WB  (RegWrite_WB),
        .stall_WBEXT  (stall_WBEXT),
        .err_timeout  (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // WB->EXT forwarding register, as the downstream stage would build it.
    logic [4:0]  rd_EXT;
    logic [31:0] data_EXT;
    always @(posedge clk) begin
        if (!rst_n) begin
            rd_EXT   <= '0;
            data_EXT <= '0;
        end else if (!stall_WBEXT) begin
            rd_EXT   <= rd_WB;
            data_EXT <= WriteData_WB;
        end
    end

    typedef struct {
        logic        busy;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic        err;
        logic [4:0]  ext_rd;
        logic [31:0] ext_data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: a load is "outstanding" for at most TO cycles.
    logic        m_busy = 1'b0;
    int          m_waited = 0;
    logic        m_pwb = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_data = '0;
    logic        m_we = 1'b0;
    logic        m_err = 1'b0;
    logic [4:0]  m_ext_rd = '0;
    logic [31:0] m_ext_data = '0;

    task automatic model_step();
        exp_t e;
        if (!rst_n) begin
            m_busy = 1'b0; m_waited = 0; m_rd = '0; m_data = '0;
            m_we = 1'b0; m_err = 1'b0; m_ext_rd = '0; m_ext_data = '0;
        end else begin
            if (m_we) begin
                m_ext_rd   = m_rd;
                m_ext_data = m_data;
            end
            if (m_busy) begin
                m_we     = 1'b0;
                m_waited = m_waited + 1;
                if (mem_rvalid) begin
                    m_data = mem_rdata;
                    m_we   = m_pwb;
                    m_busy = 1'b0;
                end else if (m_waited == int'(TO)) begin
                    m_err  = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (!valid_MEM) begin
                m_we = 1'b0;
            end else if (isLd_MEM) begin
                m_rd = rd_MEM; m_we = 1'b0; m_pwb = isWb_MEM;
                m_busy = 1'b1; m_waited = 0;
            end else begin
                m_we = isWb_MEM;
                if (isCall_MEM) begin
                    m_rd   = 5'd15;
                    m_data = PC_MEM + 32'd4;
                end else begin
                    m_rd   = rd_MEM;
                    m_data = ALUResult_MEM;
                end
            end
        end
        e.busy = m_busy; e.rd = m_rd; e.data = m_data; e.we = m_we; e.err = m_err;
        e.ext_rd = m_ext_rd; e.ext_data = m_ext_data;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare the outputs of every cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("stall_MEM", {31'd0, stall_MEM}, {31'd0, e.busy});
                chk("rd_WB", {27'd0, rd_WB}, {27'd0, e.rd});
                chk("WriteData_WB", WriteData_WB, e.data);
                chk("RegWrite_WB", {31'd0, RegWrite_WB}, {31'd0, e.we});
                chk("stall_WBEXT", {31'd0, stall_WBEXT}, {31'd0, ~e.we});
                chk("err_timeout", {31'd0, err_timeout}, {31'd0, e.err});
                chk("rd_EXT", {27'd0, rd_EXT}, {27'd0, e.ext_rd});
                chk("data_EXT", data_EXT, e.ext_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input int unsigned v, input int unsigned r, input int unsigned a,
                         input int unsigned p, input int unsigned w, input int unsigned ld,
                         input int unsigned cl, input int unsigned rv,
                         input int unsigned rdat, input int unsigned rs);
        valid_MEM     = v[0];
        rd_MEM        = r[4:0];
        ALUResult_MEM = a;
        PC_MEM        = p;
        isWb_MEM      = w[0];
        isLd_MEM      = ld[0];
        isCall_MEM    = cl[0];
        mem_rvalid    = rv[0];
        mem_rdata     = rdat;
        rst_n         = rs[0];
        tick();
    endtask

    task automatic bubble(input int unsigned rv, input int unsigned rdat,
                          input int unsigned rs);
        drive(0, 0, 0, 0, 0, 0, 0, rv, rdat, rs);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bubble(0, 0, 0);
        // add, then call
        drive(1, 3, 32'hAA, 32'h0, 1, 0, 0, 0, 0, 1);
        drive(1, 7, 32'h55, 32'h100, 1, 0, 1, 0, 0, 1);
        // load with data three cycles later, add accepted in DONE
        drive(1, 5, 0, 32'h200, 1, 1, 0, 0, 0, 1);
        bubble(0, 0, 1);
        bubble(0, 0, 1);
        bubble(1, 32'h12345678, 1);
        drive(1, 9, 32'hBEEF, 0, 1, 0, 0, 0, 0, 1);
        bubble(0, 0, 1);
        // timeout, then a late rvalid
        drive(1, 6, 0, 0, 1, 1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) bubble(0, 0, 1);
        bubble(1, 32'hDEAD0001, 1);
        bubble(0, 0, 1);
        // rvalid in the final timeout cycle
        drive(1, 8, 0, 0, 1, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) bubble(0, 0, 1);
        bubble(1, 32'hCAFEF00D, 1);
        bubble(0, 0, 1);
        // reset mid-WAIT, later rvalid ignored
        drive(1, 10, 0, 0, 1, 1, 0, 0, 0, 1);
        bubble(0, 0, 1);
        bubble(0, 0, 0);
        bubble(1, 32'h0BAD0BAD, 1);
        bubble(0, 0, 1);
        // bubble between two adds
        drive(1, 11, 32'h11, 0, 1, 0, 0, 0, 0, 1);
        bubble(0, 0, 1);
        drive(1, 12, 32'h22, 0, 1, 0, 0, 0, 0, 1);
        bubble(0, 0, 1);
        // back-to-back loads
        drive(1, 13, 0, 0, 1, 1, 0, 0, 0, 1);
        bubble(1, 32'h13131313, 1);
        drive(1, 14, 0, 0, 0, 1, 0, 0, 0, 1);
        bubble(1, 32'h14141414, 1);
        bubble(0, 0, 1);
        // random traffic
        for (int i = 0; i < 800; i++) begin
            int unsigned ld;
            int unsigned cl;
            int unsigned rv_pct;
            rv_pct = (i < 400) ? 35 : 15;
            ld = ($urandom_range(0, 99) < 30) ? 1 : 0;
            cl = (ld == 0 && $urandom_range(0, 99) < 20) ? 1 : 0;
            drive(($urandom_range(0, 99) < 80) ? 1 : 0, $urandom, $urandom, $urandom,
                  ($urandom_range(0, 3) != 0) ? 1 : 0, ld, cl,
                  ($urandom_range(0, 99) < rv_pct) ? 1 : 0, $urandom,
                  ($urandom_range(0, 99) < 2) ? 0 : 1);
        end
        bubble(0, 0, 1);
        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
